// File: rtl/bs_word_packer.sv
// Word packer feeding Barrel_Shifter: gathers N words into one frame plus a shift amount.
// Define BS_PACK_PINGPONG_EN to add a second frame bank so one frame fills while another is held.
module bs_word_packer #(
    parameter int BIT_WIDTH = 8,
    parameter int N         = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BIT_WIDTH-1:0]   word_in,
    input  logic [$clog2(N)-1:0]   shift_in,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BIT_WIDTH*N-1:0] OUT,
    output logic [$clog2(N)-1:0]   Shift,
    output logic [$clog2(N)-1:0]   fill_level
);

    localparam int LW = $clog2(N);
    localparam int FW = BIT_WIDTH * N;
    localparam logic [LW-1:0] LAST_LANE = LW'(N - 1);
    localparam logic [LW-1:0] ONE_LANE  = LW'(32'd1);
    localparam logic [LW-1:0] ZERO_LANE = {LW{1'b0}};

    // State describes the filling bank; in single-bank mode that bank is also the output.
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [LW-1:0]  fill_q, fill_d;
    logic [FW-1:0]  bank_q, bank_d;
    logic [LW-1:0]  bank_shift_q, bank_shift_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           accept_s;
    logic           handshake_s;

    assign accept_s    = in_valid & in_ready_q;
    assign handshake_s = out_valid_q & out_ready;

`ifdef BS_PACK_PINGPONG_EN
    logic [FW-1:0] out_q, out_d;
    logic [LW-1:0] out_shift_q, out_shift_d;
    logic          out_free_s;

    // The output slot can take a new frame if it is empty or being consumed this cycle.
    assign out_free_s = ~out_valid_q | handshake_s;

    // Next-state: filling bank, output slot, and the hand-over between them.
    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        bank_d       = bank_q;
        bank_shift_d = bank_shift_q;
        out_d        = out_q;
        out_shift_d  = out_shift_q;
        out_valid_d  = out_valid_q & ~handshake_s;
        case (state_q)
            ST_FILL: begin
                if (flush) begin
                    fill_d = ZERO_LANE;
                end else if (accept_s) begin
                    bank_d[int'(fill_q)*BIT_WIDTH +: BIT_WIDTH] = word_in;
                    if (fill_q == LAST_LANE) begin
                        fill_d = ZERO_LANE;
                        // A completed frame bypasses straight to the output when the slot frees up.
                        if (out_free_s) begin
                            out_d       = bank_d;
                            out_shift_d = shift_in;
                            out_valid_d = 1'b1;
                        end else begin
                            bank_shift_d = shift_in;
                            state_d      = ST_FULL;
                        end
                    end else begin
                        fill_d = fill_q + ONE_LANE;
                    end
                end else begin
                    fill_d = fill_q;
                end
            end
            ST_FULL: begin
                if (handshake_s) begin
                    out_d       = bank_q;
                    out_shift_d = bank_shift_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_FILL;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
        in_ready_d = (state_d == ST_FILL);
    end

    // Output slot registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q       <= {FW{1'b0}};
            out_shift_q <= ZERO_LANE;
        end else begin
            out_q       <= out_d;
            out_shift_q <= out_shift_d;
        end
    end

    assign OUT   = out_q;
    assign Shift = out_shift_q;
`else
    // Next-state: single bank that fills, then holds until the consumer takes it.
    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        bank_d       = bank_q;
        bank_shift_d = bank_shift_q;
        case (state_q)
            ST_FILL: begin
                if (flush) begin
                    fill_d = ZERO_LANE;
                end else if (accept_s) begin
                    bank_d[int'(fill_q)*BIT_WIDTH +: BIT_WIDTH] = word_in;
                    if (fill_q == LAST_LANE) begin
                        fill_d       = ZERO_LANE;
                        bank_shift_d = shift_in;
                        state_d      = ST_FULL;
                    end else begin
                        fill_d = fill_q + ONE_LANE;
                    end
                end else begin
                    fill_d = fill_q;
                end
            end
            ST_FULL: begin
                if (handshake_s) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
        in_ready_d  = (state_d == ST_FILL);
        out_valid_d = (state_d == ST_FULL);
    end

    assign OUT   = bank_q;
    assign Shift = bank_shift_q;
`endif

    // Filling-bank state and the registered handshake flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_FILL;
            fill_q       <= ZERO_LANE;
            bank_q       <= {FW{1'b0}};
            bank_shift_q <= ZERO_LANE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            bank_q       <= bank_d;
            bank_shift_q <= bank_shift_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign fill_level = fill_q;

endmodule

// File: tb/tb_bs_word_packer.sv
// Self-checking bench for bs_word_packer: a queue-based frame model checked every cycle,
// plus directed scenarios with hand-computed frames.
module tb_bs_word_packer;

    localparam int BW = 8;
    localparam int N  = 16;
    localparam int LW = 4;
`ifdef BS_PACK_PINGPONG_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [BW*N-1:0] d;
        logic [LW-1:0]   s;
    } frm_t;

    logic            clk       = 1'b0;
    logic            reset     = 1'b1;
    logic            in_valid  = 1'b0;
    logic            flush     = 1'b0;
    logic            out_ready = 1'b0;
    logic [BW-1:0]   word_in   = 8'h00;
    logic [LW-1:0]   shift_in  = 4'h0;
    logic            in_ready;
    logic            out_valid;
    logic [BW*N-1:0] OUT;
    logic [LW-1:0]   Shift;
    logic [LW-1:0]   fill_level;

    int n_checks = 0;
    int n_errors = 0;

    frm_t          pend_q[$];
    logic [BW-1:0] part_q[$];

    bs_word_packer #(.BIT_WIDTH(BW), .N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .word_in    (word_in),
        .shift_in   (shift_in),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .OUT        (OUT),
        .Shift      (Shift),
        .fill_level (fill_level)
    );

    always #5 clk = ~clk;

    // Model: frames completed but not yet taken, and words of the frame being gathered.
    task automatic model_clear();
        pend_q.delete();
        part_q.delete();
    endtask

    task automatic model_step(input int n_pend);
        frm_t f;
        bit   acc;
        acc = in_valid && (n_pend < CAP);
        if (n_pend > 0 && out_ready) void'(pend_q.pop_front());
        if (flush) begin
            part_q.delete();
        end else if (acc) begin
            part_q.push_back(word_in);
            if (part_q.size() == N) begin
                for (int k = 0; k < N; k++) f.d[k*BW +: BW] = part_q[k];
                f.s = shift_in;
                pend_q.push_back(f);
                part_q.delete();
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_clear();
        else        model_step(pend_q.size());
    end

    task automatic chk(input string name, input logic [BW*N-1:0] act, input logic [BW*N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("in_ready",   128'(in_ready),   128'(pend_q.size() < CAP));
        chk("out_valid",  128'(out_valid),  128'(pend_q.size() > 0));
        chk("fill_level", 128'(fill_level), 128'(part_q.size()));
        if (pend_q.size() > 0) begin
            chk("OUT",   OUT,          pend_q[0].d);
            chk("Shift", 128'(Shift),  128'(pend_q[0].s));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic send_word(input logic [BW-1:0] w, input logic [LW-1:0] sh);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        word_in  = w;
        shift_in = sh;
        for (int c = 0; c < 64 && !acc; c++) begin
            acc = (pend_q.size() < CAP);
            tick();
        end
        in_valid = 1'b0;
        chk("send_accept", 128'(acc), 128'(1'b1));
    endtask

    task automatic send_frame(input logic [BW-1:0] base, input logic [LW-1:0] sh);
        for (int k = 0; k < N; k++) send_word(base + 8'(k), (k == N - 1) ? sh : 4'h0);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Reset asserted between clock edges must clear the outputs without waiting for a clock.
    task automatic mid_reset(input string tag);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk({tag, "_iready"}, 128'(in_ready),   128'(1'b1));
        chk({tag, "_ovalid"}, 128'(out_valid),  128'(1'b0));
        chk({tag, "_out"},    OUT,              128'h0);
        chk({tag, "_shift"},  128'(Shift),      128'h0);
        chk({tag, "_fill"},   128'(fill_level), 128'h0);
        tick();
        reset = 1'b1;
    endtask

    initial begin
        bit will_acc;
        int stamps[$];
        #1 reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;

        // Frame 0x00..0x0F with shift 4, held while out_ready is low.
        send_frame(8'h00, 4'd4);
        chk("t2_ovalid", 128'(out_valid), 128'(1'b1));
        chk("t2_out",    OUT, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("t2_shift",  128'(Shift), 128'(4'd4));
        repeat (5) begin
            tick();
            chk("t2_hold_out",    OUT, 128'h0F0E0D0C0B0A09080706050403020100);
            chk("t2_hold_shift",  128'(Shift), 128'(4'd4));
            chk("t2_hold_ovalid", 128'(out_valid), 128'(1'b1));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t2_ovalid_drop", 128'(out_valid), 128'(1'b0));
        chk("t2_iready_back", 128'(in_ready),  128'(1'b1));

        // Back-pressure: a word held for 20 cycles becomes lane 0 of the next frame.
        do_reset();
        send_frame(8'h10, 4'd7);
        in_valid = 1'b1;
        word_in  = 8'hC5;
        shift_in = 4'h0;
        repeat (20) begin
            tick();
`ifndef BS_PACK_PINGPONG_EN
            chk("t3_iready_low", 128'(in_ready), 128'(1'b0));
`endif
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send_word(8'hC5, 4'h0);
        for (int k = 1; k < N; k++) send_word(8'hD0 + 8'(k), (k == N - 1) ? 4'd2 : 4'd0);
`ifndef BS_PACK_PINGPONG_EN
        chk("t3_out", OUT, 128'hDFDEDDDCDBDAD9D8D7D6D5D4D3D2D1C5);
`endif
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;

        // Flush together with a word discards the partial frame and that word.
        do_reset();
        for (int k = 0; k < 5; k++) send_word(8'h50 + 8'(k), 4'h0);
        chk("t4_fill5", 128'(fill_level), 128'(4'd5));
        in_valid = 1'b1;
        word_in  = 8'h66;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t4_fill_zero", 128'(fill_level), 128'h0);
        send_frame(8'hA0, 4'd9);
        chk("t4_out",    OUT, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
        chk("t4_shift",  128'(Shift), 128'(4'd9));
        chk("t4_ovalid", 128'(out_valid), 128'(1'b1));

        // Asynchronous reset while a frame is held, then while a frame is partly filled.
        do_reset();
        send_frame(8'h20, 4'd3);
        mid_reset("t1");
        for (int k = 0; k < 7; k++) send_word(8'h70 + 8'(k), 4'h0);
        chk("t5_fill7", 128'(fill_level), 128'(4'd7));
        mid_reset("t5");
        send_frame(8'h40, 4'd5);
        chk("t5_out",   OUT, 128'h4F4E4D4C4B4A49484746454443424140);
        chk("t5_shift", 128'(Shift), 128'(4'd5));

        // Randomized traffic with occasional flush and varying back-pressure.
        do_reset();
        will_acc = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!in_valid || will_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                word_in  = 8'($urandom);
                shift_in = 4'($urandom);
            end
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = (cyc < 1000) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0);
            will_acc  = in_valid && (pend_q.size() < CAP);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;

`ifdef BS_PACK_PINGPONG_EN
        // Continuous 48-word stream: no stall, one frame every 16 cycles.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3 * N; i++) begin
            word_in  = 8'(i);
            shift_in = 4'(i / N + 1);
            chk("t6_iready", 128'(in_ready), 128'(1'b1));
            tick();
            if (out_valid) stamps.push_back(i);
        end
        in_valid = 1'b0;
        for (int i = 3 * N; i < 3 * N + 4; i++) begin
            tick();
            if (out_valid) stamps.push_back(i);
        end
        chk("t6_frames", 128'(stamps.size()), 128'(3));
        if (stamps.size() == 3) begin
            chk("t6_gap1", 128'(stamps[1] - stamps[0]), 128'(N));
            chk("t6_gap2", 128'(stamps[2] - stamps[1]), 128'(N));
        end
        out_ready = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
